// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter that time-shares one 4-digit ASCII 7-segment display among NREQ string sources.
// Optional build macro PRIORITY_PREEMPT_EN: requester 0 preempts other owners and wins every arbitration.
module seg_disp_arbiter #(
  parameter int NREQ         = 4,
  parameter int HOLD_CYCLES  = 50000000,
  parameter int GUARD_CYCLES = 1000000,
  parameter int CNT_W        = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   str_in,
  output logic [NREQ-1:0]      grant,
  output logic [31:0]          show_string,
  output logic                 disp_en,
  output logic [2:0]           owner_id
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHOW  = 2'd1;
  localparam logic [1:0] S_GUARD = 2'd2;

  localparam logic [31:0]      BLANK      = 32'h20202020;
  localparam logic [CNT_W-1:0] HOLD_MAX   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [2:0]       LAST_ID    = 3'(NREQ - 1);

  logic [1:0]       state;
  logic [2:0]       rr;
  logic [CNT_W-1:0] timer;

  logic             pick_valid;
  logic [2:0]       pick_idx;
  logic [31:0]      pick_str;
  logic [31:0]      owner_str;
  logic             owner_req;
  logic             others_req;
  logic             hold_done;
  logic             release_now;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(rr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!pick_valid && req[j]) begin
        pick_valid = 1'b1;
        pick_idx   = 3'(j);
      end
    end
`ifdef PRIORITY_PREEMPT_EN
    if (req[0]) begin
      pick_valid = 1'b1;
      pick_idx   = 3'd0;
    end
`endif
  end

  always_comb begin
    pick_str  = BLANK;
    owner_str = BLANK;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == pick_idx) pick_str  = str_in[32*i +: 32];
      if (3'(i) == owner_id) owner_str = str_in[32*i +: 32];
    end
  end

  // The timer saturates at HOLD_MAX, so ">= HOLD_LAST" stays true once the hold has elapsed.
  assign owner_req  = |(req & grant);
  assign others_req = |(req & ~grant);
  assign hold_done  = (timer >= HOLD_LAST);

`ifdef PRIORITY_PREEMPT_EN
  assign release_now = !owner_req || (hold_done && others_req) || (req[0] && (owner_id != 3'd0));
`else
  assign release_now = !owner_req || (hold_done && others_req);
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr          <= 3'd0;
      timer       <= '0;
      grant       <= '0;
      show_string <= BLANK;
      disp_en     <= 1'b0;
      owner_id    <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            state       <= S_SHOW;
            grant       <= NREQ'(1) << pick_idx;
            owner_id    <= pick_idx;
            disp_en     <= 1'b1;
            show_string <= pick_str;
            timer       <= '0;
          end
        end

        S_SHOW: begin
          if (release_now) begin
            state       <= S_GUARD;
            rr          <= (owner_id == LAST_ID) ? 3'd0 : 3'(owner_id + 3'd1);
            grant       <= '0;
            disp_en     <= 1'b0;
            show_string <= BLANK;
            timer       <= '0;
          end else begin
            show_string <= owner_str;
            if (timer != HOLD_MAX) timer <= timer + CNT_W'(1);
          end
        end

        S_GUARD: begin
          if (timer == GUARD_LAST) begin
            timer <= '0;
            if (pick_valid) begin
              state       <= S_SHOW;
              grant       <= NREQ'(1) << pick_idx;
              owner_id    <= pick_idx;
              disp_en     <= 1'b1;
              show_string <= pick_str;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
